// File: rtl/rtc_timekeeper_pkg.sv
// Shared widths, moduli and hour-format helper for the RTC timekeeper.
package rtc_pkg;

    localparam int SEC_PER_MIN  = 60;
    localparam int MIN_PER_HOUR = 60;
    localparam int HOUR_PER_DAY = 24;
    localparam int HOUR_W       = 5;
    localparam int MIN_W        = 6;
    localparam int SEC_W        = 6;

    typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

    // 0 shows as 12, afternoon hours fold down by 12.
    function automatic logic [HOUR_W-1:0] hour_12h(input logic [HOUR_W-1:0] h);
        if (h == '0) return HOUR_W'(12);
        if (h > HOUR_W'(12)) return h - HOUR_W'(12);
        return h;
    endfunction

endpackage

// File: rtl/rtc_timekeeper_if.sv
// Time-set request bus: a one-cycle load request with a rejection pulse back.
interface rtc_timekeeper_if;
    import rtc_pkg::*;

    logic              set_valid;
    logic [HOUR_W-1:0] set_hours;
    logic [MIN_W-1:0]  set_minutes;
    logic [SEC_W-1:0]  set_seconds;
    logic              set_err;

    modport master (output set_valid, set_hours, set_minutes, set_seconds, input set_err);
    modport slave  (input set_valid, set_hours, set_minutes, set_seconds, output set_err);
endinterface

// File: rtl/rtc_timekeeper_mod_counter.sv
// Modulo-MOD counter with synchronous load; wrap flags the MOD-1 -> 0 step.
module mod_counter #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign wrap = inc && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (load) cnt <= load_val;
        else if (inc)  cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/rtc_timekeeper.sv
// Synchronous timekeeper: prescaler with PPS discipline driving a sec/min/hour
// cascade, validated time set, registered tick strobes and 12/24 h output.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int DIV         = 100,
    parameter int PPS_GUARD   = DIV / 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                run_en,
    input  logic                                pps,
    input  logic                                mode_12h,
    rtc_timekeeper_if.slave                     set_bus,
    output logic [HOUR_W-1:0]                   hours,
    output logic                                pm,
    output logic [MIN_W-1:0]                    minutes,
    output logic [SEC_W-1:0]                    seconds,
    output logic [$clog2(DIV+PPS_GUARD)-1:0]    subsec,
    output logic                                sec_tick,
    output logic                                min_tick,
    output logic                                hour_tick,
    output logic                                day_tick,
    output logic                                pps_locked
);
    localparam int SUB_W = $clog2(DIV + PPS_GUARD);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(DIV - 1);
    localparam logic [SUB_W-1:0] SUB_GUARD = SUB_W'(DIV - 1 + PPS_GUARD);

    logic [SYNC_STAGES-1:0] pps_sync;
    logic                   pps_prev;
    logic                   pps_edge;
    lock_state_e            state;
    logic                   set_ok;
    logic                   adv;
    logic                   set_err_q;
    logic                   sec_wrap, min_wrap, hour_wrap;
    logic [HOUR_W-1:0]      hour24;

    // Edge flop keeps tracking while frozen so a stale level never looks like a new edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pps_sync <= '0;
            pps_prev <= 1'b0;
        end else begin
            pps_sync <= {pps_sync[SYNC_STAGES-2:0], pps};
            pps_prev <= pps_sync[SYNC_STAGES-1];
        end
    end

    assign pps_edge = pps_sync[SYNC_STAGES-1] & ~pps_prev;

    assign set_ok = set_bus.set_valid
                 && (set_bus.set_hours   < HOUR_W'(HOUR_PER_DAY))
                 && (set_bus.set_minutes < MIN_W'(MIN_PER_HOUR))
                 && (set_bus.set_seconds < SEC_W'(SEC_PER_MIN));

    // The first edge while unlocked only aligns phase; it does not count a second.
    always_comb begin
        adv = 1'b0;
        if (run_en && !set_ok) begin
            case (state)
                UNLOCKED: adv = !pps_edge && (subsec == SUB_LAST);
                LOCKED:   adv = pps_edge || (subsec == SUB_GUARD);
                default:  adv = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= UNLOCKED;
            subsec    <= '0;
            set_err_q <= 1'b0;
            sec_tick  <= 1'b0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
        end else begin
            set_err_q <= set_bus.set_valid && !set_ok;
            sec_tick  <= adv;
            min_tick  <= sec_wrap;
            hour_tick <= min_wrap;
            day_tick  <= hour_wrap;
            if (set_ok) begin
                subsec <= '0;
            end else if (run_en) begin
                case (state)
                    UNLOCKED: begin
                        if (pps_edge) begin
                            state  <= LOCKED;
                            subsec <= '0;
                        end else if (subsec == SUB_LAST) subsec <= '0;
                        else subsec <= subsec + 1'b1;
                    end
                    LOCKED: begin
                        if (pps_edge) subsec <= '0;
                        else if (subsec == SUB_GUARD) begin
                            state  <= UNLOCKED;
                            subsec <= '0;
                        end else subsec <= subsec + 1'b1;
                    end
                    default: state <= UNLOCKED;
                endcase
            end
        end
    end

    mod_counter #(.MOD(SEC_PER_MIN), .W(SEC_W)) u_sec (
        .clk(clk), .rst(rst), .inc(adv), .load(set_ok),
        .load_val(set_bus.set_seconds), .cnt(seconds), .wrap(sec_wrap)
    );

    mod_counter #(.MOD(MIN_PER_HOUR), .W(MIN_W)) u_min (
        .clk(clk), .rst(rst), .inc(sec_wrap), .load(set_ok),
        .load_val(set_bus.set_minutes), .cnt(minutes), .wrap(min_wrap)
    );

    mod_counter #(.MOD(HOUR_PER_DAY), .W(HOUR_W)) u_hour (
        .clk(clk), .rst(rst), .inc(min_wrap), .load(set_ok),
        .load_val(set_bus.set_hours), .cnt(hour24), .wrap(hour_wrap)
    );

    assign set_bus.set_err = set_err_q;
    assign pps_locked      = (state == LOCKED);
    assign pm              = (hour24 >= HOUR_W'(12));
    assign hours           = mode_12h ? hour_12h(hour24) : hour24;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// Randomized bench for rtc_timekeeper against a time-of-day reference model.
module tb_rtc_timekeeper;
    localparam int DIV = 4;
    localparam int G   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run_en = 1'b0;
    logic       pps = 1'b0;
    logic       mode_12h = 1'b0;
    logic [4:0] hours;
    logic       pm;
    logic [5:0] minutes, seconds;
    logic [2:0] subsec;
    logic       sec_tick, min_tick, hour_tick, day_tick, pps_locked;

    rtc_timekeeper_if bus();

    rtc_timekeeper #(.DIV(DIV), .PPS_GUARD(G), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .pps(pps), .mode_12h(mode_12h),
        .set_bus(bus), .hours(hours), .pm(pm), .minutes(minutes), .seconds(seconds),
        .subsec(subsec), .sec_tick(sec_tick), .min_tick(min_tick),
        .hour_tick(hour_tick), .day_tick(day_tick), .pps_locked(pps_locked)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference: time of day in seconds, prescaler phase, lock flag, pps samples.
    int tod = 0;
    int phase = 0;
    bit locked = 1'b0;
    bit ph[4] = '{0, 0, 0, 0};
    int e_strb = 0;
    bit e_err = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        tod = 0; phase = 0; locked = 1'b0; e_strb = 0; e_err = 1'b0;
        for (int i = 0; i < 4; i++) ph[i] = 1'b0;
    endtask

    task automatic model_update();
        bit edge_seen, adv, ok;
        ph[3] = ph[2]; ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = pps;
        edge_seen = ph[2] && !ph[3];
        ok = bus.set_valid && bus.set_hours < 24 && bus.set_minutes < 60 && bus.set_seconds < 60;
        e_err = bus.set_valid && !ok;
        adv = 1'b0;
        if (ok) begin
            tod = int'(bus.set_hours) * 3600 + int'(bus.set_minutes) * 60 + int'(bus.set_seconds);
            phase = 0;
        end else if (run_en) begin
            if (edge_seen) begin
                adv = locked;
                locked = 1'b1;
                phase = 0;
            end else if (!locked && phase == DIV - 1) begin
                adv = 1'b1; phase = 0;
            end else if (locked && phase == DIV - 1 + G) begin
                adv = 1'b1; phase = 0; locked = 1'b0;
            end else phase++;
        end
        if (adv) tod = (tod + 1) % 86400;
        e_strb = {adv, adv && tod % 60 == 0, adv && tod % 3600 == 0, adv && tod == 0};
    endtask

    task automatic check_all();
        int h, eh;
        h  = tod / 3600;
        eh = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
        chk("hours", int'(hours), eh);
        chk("pm", int'(pm), int'(h >= 12));
        chk("minutes", int'(minutes), (tod / 60) % 60);
        chk("seconds", int'(seconds), tod % 60);
        chk("subsec", int'(subsec), phase);
        chk("strobes", int'({sec_tick, min_tick, hour_tick, day_tick}), e_strb);
        chk("set_err", int'(bus.set_err), int'(e_err));
        chk("pps_locked", int'(pps_locked), int'(locked));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        bus.set_valid = 1'b1;
        bus.set_hours = 5'(h); bus.set_minutes = 6'(m); bus.set_seconds = 6'(s);
        step();
        bus.set_valid = 1'b0;
    endtask

    initial begin
        int n_sec;
        int per;
        int pers[6] = '{0, 4, 5, 6, 7, 9};

        bus.set_valid = 1'b0;
        bus.set_hours = '0; bus.set_minutes = '0; bus.set_seconds = '0;
        model_reset();
        #1 check_all();
        mode_12h = 1'b1;
        #1 check_all();
        mode_12h = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_en = 1'b1;

        // Free-running: one minute of seconds at DIV cycles each.
        n_sec = 0;
        for (int c = 0; c < 4 * 60; c++) begin
            step();
            if (sec_tick) n_sec++;
        end
        chk("sec_tick_count", n_sec, 60);
        chk("minute_after_60s", int'(minutes), 1);

        // Day rollover with all strobes together, shown in 12 h mode.
        set_time(23, 59, 59);
        mode_12h = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("day_roll_strobes", int'({sec_tick, min_tick, hour_tick, day_tick}), 15);
        chk("midnight_12h", int'(hours), 12);
        mode_12h = 1'b0;

        // Rejected set, then a valid set colliding with a prescaler wrap.
        set_time(24, 10, 10);
        step();
        for (int c = 0; c < 8 && phase != DIV - 1; c++) step();
        set_time(1, 2, 3);
        chk("set_over_wrap_tick", int'(sec_tick), 0);
        for (int c = 0; c < 6; c++) step();

        // PPS every 5 cycles, then removed to exercise guard expiry.
        for (int c = 0; c < 60; c++) begin
            pps = (c % 5) < 2;
            step();
        end
        pps = 1'b0;
        for (int c = 0; c < 30; c++) step();

        // Frozen for 20 cycles with a pps pulse in the middle.
        run_en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            pps = (c >= 5 && c < 8);
            step();
        end
        pps = 1'b0;
        run_en = 1'b1;
        for (int c = 0; c < 12; c++) step();

        // Randomized mix of pps cadence, freezes, sets and display mode.
        per = 0;
        for (int c = 0; c < 1800; c++) begin
            if (c % 300 == 0) per = pers[$urandom_range(0, 5)];
            pps = (per != 0) && ((c % per) < 2);
            run_en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 15) == 0) mode_12h = ~mode_12h;
            bus.set_valid = ($urandom_range(0, 40) == 0);
            bus.set_hours   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(22, 23));
            bus.set_minutes = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(58, 59));
            bus.set_seconds = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(50, 59));
            step();
        end
        bus.set_valid = 1'b0;
        run_en = 1'b1;
        mode_12h = 1'b0;

        // Lock, load 12:34:56, then assert reset between clock edges.
        for (int c = 0; c < 30; c++) begin
            pps = (c % 5) < 2;
            step();
        end
        set_time(12, 34, 56);
        pps = 1'b0;
        step();
        chk("locked_before_reset", int'(pps_locked), 1);
        #2;
        rst = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
- Parametrised successor to the ripple-clocked binary clock counter chain. Fully synchronous single-clock timekeeper: prescaler, then seconds, minutes, hours (24 h internal).
- Adds runtime 12/24 h output mode, a validated time-set port, single-cycle tick strobes, and PPS discipline with lock, guard-window loss detection and fallback to the internal prescaler.
- Feeds the display multiplexer and any alarm logic.

Parameters:
- DIV, 100, clk cycles per second on the internal prescaler (>=2).
- PPS_GUARD, DIV/8, extra cycles past DIV-1 allowed in locked mode before PPS is declared lost.
- SYNC_STAGES, 2, PPS synchroniser depth (>=2).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- run_en  in  1  1 = timekeeping advances; 0 = counters and PPS handling frozen.
- pps  in  1  asynchronous pulse-per-second; rising edge significant.
- mode_12h  in  1  output hour format select (combinational effect).
- set_valid  in  1  one-cycle load request.
- set_hours  in  5  0..23
- set_minutes  in  6  0..59
- set_seconds  in  6  0..59
- set_err  out  1  one-cycle pulse, request rejected.
- hours  out  5  0..23, or 1..12 when mode_12h.
- pm  out  1  internal hour >= 12 (valid in both modes).
- minutes  out  6
- seconds  out  6
- subsec  out  $clog2(DIV+PPS_GUARD)  prescaler value.
- sec_tick, min_tick, hour_tick, day_tick  out  1  each; one-cycle strobes.
- pps_locked  out  1  seconds disciplined by PPS.

Behaviour:
- Reset (rst=0, async): hour24/min/sec/subsec=0, all strobes 0, set_err 0, pps_locked 0, synchroniser and edge flops 0. Outputs: hours=0 (12 in 12 h mode), pm=0.
- PPS path: SYNC_STAGES flops plus one edge flop. pps_edge = sync & ~prev. First observed edge 3 cycles after the pps rise (default depth).
- Advance event "adv" (only when run_en=1):
  - Unlocked: subsec==DIV-1 -> subsec=0, adv. Otherwise subsec+1.
  - Unlocked, pps_edge: pps_locked=1, subsec=0, no adv. Phase alignment only.
  - Locked, pps_edge: subsec=0, adv.
  - Locked, no edge: subsec+1. At subsec==DIV-1+PPS_GUARD: pps_locked=0, subsec=0, adv.
  - An edge in the same cycle as the guard limit counts as an edge; lock is kept.
- Cascade on adv:
  - sec 59->0 asserts min_tick and advances minutes.
  - min 59->0 asserts hour_tick and advances hours.
  - hour 23->0 asserts day_tick.
  - sec_tick on every adv. Strobes are registered and high in the same cycle the new value is visible.
- Set:
  - set_valid with hours<24, minutes<60, seconds<60: load on the next edge and clear subsec. Takes priority over adv and pps_edge in the same cycle. No strobes; pps_locked unchanged.
  - Any field out of range: no load, set_err=1 for one cycle.
  - Set is accepted regardless of run_en.
- run_en=0: subsec, counters and pps_locked hold. pps edges are discarded (edge flop still tracks). Strobes 0.
- 12 h conversion (combinational from hour24): h=0 -> 12; 1..12 -> h; 13..23 -> h-12.
- Arithmetic is unsigned with fixed widths. Illegal counter values cannot be produced.

Decomposition:
- Package rtc_pkg: SEC_PER_MIN=60, MIN_PER_HOUR=60, HOUR_PER_DAY=24, HOUR_W=5, MIN_W=6, SEC_W=6.
- Sub-module mod_counter #(MOD, W), instantiated three times for seconds, minutes and hours.
  - Ports: clk, rst, inc, load, load_val, cnt, wrap.
  - wrap is combinational: inc && cnt==MOD-1.
- The top holds the prescaler, PPS synchroniser/lock FSM (UNLOCKED/LOCKED), set validation, strobe registers and 12 h conversion.

Test Plan:
- DIV=4, run 4*60 cycles from reset -> seconds 0..59 then 0. min_tick one cycle at rollover; minutes=1; sec_tick 60 times.
- set 23:59:59 then 4 cycles -> 00:00:00 with sec_tick, min_tick, hour_tick, day_tick all high in the same cycle. mode_12h=1 shows hours=12, pm=0.
- set_hours=24 -> set_err pulse, time unchanged. Same-cycle set_valid (valid) and prescaler wrap -> loaded value, subsec=0, no sec_tick.
- DIV=4, PPS_GUARD=2, pps every 5 cycles:
  - First edge -> pps_locked=1, seconds unchanged.
  - Each later edge -> seconds+1.
  - Stop pps -> 6 cycles after the last edge pps_locked=0, seconds+1, then internal 4-cycle cadence.
- run_en=0 for 20 cycles, including a pps pulse -> all outputs hold, no strobes. Resume -> counting continues from held subsec.
- Assert rst mid-count (locked, 12:34:56) -> all outputs zero immediately without a clock edge, pps_locked=0.
